fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Producer side of the EX-stage operand-select interface.
- Tracks destination registers of in-flight instructions in EX and MEM.
- Drives registered forwarding selects (mux1_sel/mux2_sel) that arrive at EX together with the instruction.
- Detects load-use hazards, inserts bubbles, stalls IF/ID, freezes on data-memory wait and honours branch flush.

Parameters:
REG_ADDR_W, 5, register index width
FWD_SEL_W, 2, forwarding select width (00 regfile, 01 EX/MEM result, 10 MEM/WB result)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
id_valid  input  1  ID holds a real instruction
id_rs1  input  REG_ADDR_W  source 1 index
id_rs2  input  REG_ADDR_W  source 2 index
id_rs1_used  input  1  instruction reads rs1
id_rs2_used  input  1  instruction reads rs2
id_rd  input  REG_ADDR_W  destination index
id_reg_write  input  1  instruction writes rd
id_is_load  input  1  instruction is a load
flush  input  1  taken branch/jump resolved; kill ID instruction
mem_ready  input  1  data memory completes this cycle; 0 = wait
mux1_sel  output  FWD_SEL_W  registered select for EX src1
mux2_sel  output  FWD_SEL_W  registered select for EX src2
stall_if_id  output  1  hold PC and IF/ID register (combinational)
bubble_ex  output  1  registered; EX holds a bubble (suppress writes)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. On reset:
  - mux1_sel = mux2_sel = 00.
  - stall_if_id = 0, bubble_ex = 1.
  - EX and MEM tracking entries invalid.
  - FSM in RUN.
- Tracking entries:
  - ex_{valid, rd, wr, ld}: instruction now in EX.
  - mem_{valid, rd, wr}: instruction now in MEM.
- Advance (mem_ready=1 and state RUN): mem <= ex; ex <= ID instruction, or a bubble.
- Select computation (per source, only if id_valid and rsN_used):
  - If rsN == 0: select 00. x0 is never forwarded.
  - Else if ex_valid & ex_wr & ex_rd == rsN: select 01. The EX instruction moves to MEM as ID enters EX.
  - Else if mem_valid & mem_wr & mem_rd == rsN: select 10.
  - Else: select 00.
  - Priority EX > MEM (youngest wins).
- Selects and bubble_ex are registered on advance, so a select takes effect in the same cycle its instruction occupies EX.
- Load-use: ex_valid & ex_ld & ex_wr & ex_rd != 0 matching a used rsN.
  - stall_if_id = 1 in that cycle.
  - EX is loaded with a bubble (bubble_ex <= 1, selects <= 00).
  - FSM -> LD_STALL.
  - Next cycle the same ID instruction re-evaluates; the load now sits in MEM, giving select 10. FSM -> RUN.
- FSM states:
  - RUN -> LD_STALL: load-use detected.
  - LD_STALL -> RUN: unconditional, one cycle. A second back-to-back load dependency re-enters LD_STALL through RUN evaluation.
  - Any state -> MEM_WAIT: mem_ready = 0.
  - MEM_WAIT -> previous state: mem_ready = 1.
- MEM_WAIT:
  - All tracking registers, selects, bubble_ex and state are frozen.
  - stall_if_id = 1.
  - Outputs do not glitch.
- Flush (sampled only when mem_ready = 1):
  - The ID instruction is not entered; EX is loaded with a bubble.
  - A pending load-use stall is cancelled and the FSM goes to RUN.
  - stall_if_id = 0.
- Flush concurrent with mem_ready = 0: ignored this cycle. The branch source is frozen too, so flush stays asserted until mem_ready = 1.
- Flush has priority over load-use stall.
- id_valid = 0 is treated as a bubble: no hazards, selects 00.

Optional Feature:
FWD_STATS_EN
- Defined: adds outputs stall_cnt [31:0] and fwd_cnt [31:0], both reset to 0, saturating.
  - stall_cnt increments on each load-use stall cycle.
  - fwd_cnt increments on each advance where either registered select is non-zero.
  - Neither counts during MEM_WAIT.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - fwd_sel_e enum: FWD_REG = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
  - hz_state_e: RUN, LD_STALL, MEM_WAIT.
  - REG_ADDR_W constant.
  - inflight_t struct {valid, rd, wr, ld}.
- One sub-module, fwd_sel_calc: purely combinational per-source select plus load-use match. Instantiated twice (rs1, rs2).

Test Plan:
- Reset mid-run: assert rst async while state = LD_STALL -> outputs immediately mux sels 00, stall 0, bubble_ex 1, state RUN.
- EX/MEM forward: ADD x5 then ADD x6,x5,x5 back-to-back -> second instr in EX with mux1_sel = mux2_sel = 01, no stall.
- MEM/WB forward: ADD x5, NOP, SUB x7,x5,x1 -> SUB in EX with mux1_sel = 10, mux2_sel = 00. Priority: ADD x5; ADD x5; USE x5 -> 01.
- Load-use: LW x3 then ADD x4,x3,x2 -> one cycle stall_if_id = 1, bubble_ex = 1; next cycle ADD enters EX with mux1_sel = 10. rd = x0 load -> no stall.
- Memory wait: mem_ready = 0 for 3 cycles mid-forward -> stall_if_id = 1 and sels frozen for 3 cycles; forwarding resumes correctly afterwards.
- Flush vs stall: flush = 1 in the same cycle as a load-use hit -> no stall, EX bubble, state RUN. With FWD_STATS_EN: stall_cnt unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the EX-stage forwarding / hazard controller.
package pipe_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned FWD_SEL_W  = 2;
   localparam int unsigned CNT_W      = 32;

   typedef enum logic [FWD_SEL_W-1:0] {
      FWD_REG   = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      LD_STALL = 2'b01,
      MEM_WAIT = 2'b10
   } hz_state_e;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  wr;
      logic                  ld;
   } inflight_t;

   localparam inflight_t INFLIGHT_BUBBLE = inflight_t'('0);

endpackage

// File: rtl/fwd_sel_calc.sv
// Per-source forwarding select and load-use match (purely combinational).
module fwd_sel_calc
   import pipe_pkg::*;
(
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] rs_i,
   input  logic                  rs_used_i,
   input  inflight_t             ex_i,
   input  logic                  mem_valid_i,
   input  logic [REG_ADDR_W-1:0] mem_rd_i,
   input  logic                  mem_wr_i,
   output fwd_sel_e              sel_c_o,
   output logic                  load_use_c_o
);

   // Youngest producer wins; x0 is never forwarded.
   always_comb begin
      sel_c_o      = FWD_REG;
      load_use_c_o = 1'b0;
      if (id_valid_i && rs_used_i && (rs_i != '0)) begin
         if (ex_i.valid && ex_i.wr && (ex_i.rd == rs_i)) begin
            sel_c_o      = FWD_EXMEM;
            load_use_c_o = ex_i.ld;
         end else if (mem_valid_i && mem_wr_i && (mem_rd_i == rs_i)) begin
            sel_c_o = FWD_MEMWB;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand-select producer: tracks EX/MEM destinations, registers
// forwarding selects, inserts load-use bubbles, freezes on memory wait and
// honours branch flush. Optional counters under `FWD_STATS_EN`.
module fwd_hazard_ctrl
   import pipe_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_is_load,
   input  logic                  flush,
   input  logic                  mem_ready,
   output logic [FWD_SEL_W-1:0]  mux1_sel,
   output logic [FWD_SEL_W-1:0]  mux2_sel,
`ifdef FWD_STATS_EN
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      fwd_cnt,
`endif
   output logic                  stall_if_id,
   output logic                  bubble_ex
);

   hz_state_e             state_q, state_d;
   hz_state_e             prev_q, prev_d;
   hz_state_e             eff_state_c;
   inflight_t             ex_q, ex_d;
   logic                  mem_valid_q, mem_valid_d;
   logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
   logic                  mem_wr_q, mem_wr_d;
   fwd_sel_e              mux1_q, mux1_d;
   fwd_sel_e              mux2_q, mux2_d;
   logic                  bubble_q, bubble_d;
   fwd_sel_e              sel1_c, sel2_c;
   logic                  lu1_c, lu2_c;
   logic                  load_use_c;
   logic                  stall_c;

   fwd_sel_calc u_rs1 (
      .id_valid_i   (id_valid),
      .rs_i         (id_rs1),
      .rs_used_i    (id_rs1_used),
      .ex_i         (ex_q),
      .mem_valid_i  (mem_valid_q),
      .mem_rd_i     (mem_rd_q),
      .mem_wr_i     (mem_wr_q),
      .sel_c_o      (sel1_c),
      .load_use_c_o (lu1_c)
   );

   fwd_sel_calc u_rs2 (
      .id_valid_i   (id_valid),
      .rs_i         (id_rs2),
      .rs_used_i    (id_rs2_used),
      .ex_i         (ex_q),
      .mem_valid_i  (mem_valid_q),
      .mem_rd_i     (mem_rd_q),
      .mem_wr_i     (mem_wr_q),
      .sel_c_o      (sel2_c),
      .load_use_c_o (lu2_c)
   );

   // State the pipeline is really in once a memory wait resolves.
   assign eff_state_c = (state_q == MEM_WAIT) ? prev_q : state_q;

   // Load-use only from RUN; LD_STALL always returns to RUN after one cycle.
   assign load_use_c = (eff_state_c == RUN) && (lu1_c || lu2_c);

   // Next-state, tracking advance and combinational stall.
   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      ex_d        = ex_q;
      mem_valid_d = mem_valid_q;
      mem_rd_d    = mem_rd_q;
      mem_wr_d    = mem_wr_q;
      mux1_d      = mux1_q;
      mux2_d      = mux2_q;
      bubble_d    = bubble_q;
      stall_c     = 1'b0;

      if (!mem_ready) begin
         // Freeze everything; remember where to resume.
         stall_c = 1'b1;
         state_d = MEM_WAIT;
         if (state_q != MEM_WAIT) begin
            prev_d = state_q;
         end
      end else begin
         mem_valid_d = ex_q.valid;
         mem_rd_d    = ex_q.rd;
         mem_wr_d    = ex_q.wr;
         ex_d        = INFLIGHT_BUBBLE;
         mux1_d      = FWD_REG;
         mux2_d      = FWD_REG;
         bubble_d    = 1'b1;
         state_d     = RUN;
         prev_d      = RUN;
         if (flush) begin
            // Killed ID instruction: bubble into EX, any stall cancelled.
            state_d = RUN;
         end else if (load_use_c) begin
            stall_c = 1'b1;
            state_d = LD_STALL;
         end else if (id_valid) begin
            ex_d.valid = 1'b1;
            ex_d.rd    = id_rd;
            ex_d.wr    = id_reg_write;
            ex_d.ld    = id_is_load;
            mux1_d     = sel1_c;
            mux2_d     = sel2_c;
            bubble_d   = 1'b0;
         end
      end
   end

   // Pipeline tracking, selects and FSM state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         prev_q      <= RUN;
         ex_q        <= INFLIGHT_BUBBLE;
         mem_valid_q <= 1'b0;
         mem_rd_q    <= '0;
         mem_wr_q    <= 1'b0;
         mux1_q      <= FWD_REG;
         mux2_q      <= FWD_REG;
         bubble_q    <= 1'b1;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         ex_q        <= ex_d;
         mem_valid_q <= mem_valid_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         mux1_q      <= mux1_d;
         mux2_q      <= mux2_d;
         bubble_q    <= bubble_d;
      end
   end

   assign mux1_sel    = mux1_q;
   assign mux2_sel    = mux2_q;
   assign bubble_ex   = bubble_q;
   assign stall_if_id = stall_c;

`ifdef FWD_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] fwd_cnt_q;

   // Saturating stall / forward event counters, idle during memory wait.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else if (mem_ready) begin
         if (!flush && load_use_c && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (((mux1_d != FWD_REG) || (mux2_d != FWD_REG)) && (fwd_cnt_q != '1)) begin
            fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed self-checking bench for fwd_hazard_ctrl (optionally with FWD_STATS_EN).
module tb_fwd_hazard_ctrl;
   import pipe_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
   logic                  id_rs1_used, id_rs2_used, id_reg_write, id_is_load;
   logic                  flush, mem_ready;
   logic [FWD_SEL_W-1:0]  mux1_sel, mux2_sel;
   logic                  stall_if_id, bubble_ex;
`ifdef FWD_STATS_EN
   logic [CNT_W-1:0]      stall_cnt, fwd_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   fwd_hazard_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs1_used  (id_rs1_used),
      .id_rs2_used  (id_rs2_used),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_is_load   (id_is_load),
      .flush        (flush),
      .mem_ready    (mem_ready),
      .mux1_sel     (mux1_sel),
      .mux2_sel     (mux2_sel),
`ifdef FWD_STATS_EN
      .stall_cnt    (stall_cnt),
      .fwd_cnt      (fwd_cnt),
`endif
      .stall_if_id  (stall_if_id),
      .bubble_ex    (bubble_ex)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [1:0] m1, input logic [1:0] m2, input logic b);
      chk({tag, "_mux1"}, 32'(mux1_sel), 32'(m1));
      chk({tag, "_mux2"}, 32'(mux2_sel), 32'(m2));
      chk({tag, "_bubble"}, 32'(bubble_ex), 32'(b));
   endtask

   task automatic chk_state(input string tag, input hz_state_e s);
      chk({tag, "_state"}, 32'(dut.state_q), 32'(s));
   endtask

   task automatic chk_stall(input string tag, input logic s);
      #1;
      chk({tag, "_stall"}, 32'(stall_if_id), 32'(s));
   endtask

   task automatic chk_stats(input string tag, input int sc, input int fc);
`ifdef FWD_STATS_EN
      chk({tag, "_stall_cnt"}, stall_cnt, 32'(sc));
      chk({tag, "_fwd_cnt"}, fwd_cnt, 32'(fc));
`else
      if (tag.len() > 0 && sc + fc < 0) $display("%s", tag);
`endif
   endtask

   task automatic id_set(input logic v, input logic [REG_ADDR_W-1:0] r1, input logic u1,
                         input logic [REG_ADDR_W-1:0] r2, input logic u2,
                         input logic [REG_ADDR_W-1:0] rd, input logic wr, input logic ld);
      id_valid     = v;
      id_rs1       = r1;
      id_rs1_used  = u1;
      id_rs2       = r2;
      id_rs2_used  = u2;
      id_rd        = rd;
      id_reg_write = wr;
      id_is_load   = ld;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      mem_ready = 1'b1;
      id_set(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk_out("reset", 2'b00, 2'b00, 1'b1);
      chk("reset_stall", 32'(stall_if_id), 32'd0);
      chk_state("reset", RUN);
      chk_stats("reset", 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // EX/MEM forward: ADD x5 ; ADD x6,x5,x5
      id_set(1, 1, 1, 2, 1, 5, 1, 0); tick();
      chk_out("A", 2'b00, 2'b00, 1'b0);
      id_set(1, 5, 1, 5, 1, 6, 1, 0); chk_stall("B", 1'b0); tick();
      chk_out("B_exmem", 2'b01, 2'b01, 1'b0);

      // MEM/WB forward: ADD x5 ; NOP ; SUB x7,x5,x1
      id_set(1, 1, 1, 2, 1, 5, 1, 0); tick();
      chk_out("C", 2'b00, 2'b00, 1'b0);
      id_set(0, 0, 0, 0, 0, 0, 0, 0); tick();
      chk_out("D_nop", 2'b00, 2'b00, 1'b1);
      id_set(1, 5, 1, 1, 1, 7, 1, 0); tick();
      chk_out("E_memwb", 2'b10, 2'b00, 1'b0);

      // Priority: ADD x5 ; ADD x5 ; USE x5 -> youngest
      id_set(1, 0, 1, 0, 1, 5, 1, 0); tick();
      id_set(1, 3, 1, 0, 0, 5, 1, 0); tick();
      id_set(1, 5, 1, 5, 1, 8, 1, 0); tick();
      chk_out("H_prio", 2'b01, 2'b01, 1'b0);

      // x0 never forwarded even when EX writes x0
      id_set(1, 3, 1, 4, 1, 0, 1, 0); tick();
      id_set(1, 0, 1, 0, 1, 9, 0, 0); tick();
      chk_out("J_x0", 2'b00, 2'b00, 1'b0);

      // Load-use: LW x3 ; ADD x4,x3,x2
      id_set(1, 1, 1, 0, 0, 3, 1, 1); tick();
      id_set(1, 3, 1, 2, 1, 4, 1, 0); chk_stall("L_lu", 1'b1); tick();
      chk_out("L_lu", 2'b00, 2'b00, 1'b1);
      chk_state("L_lu", LD_STALL);
      chk_stall("M", 1'b0); tick();
      chk_out("M_after_lu", 2'b10, 2'b00, 1'b0);
      chk_state("M", RUN);
      chk_stats("M", 1, 4);

      // Load to x0 never stalls
      id_set(1, 1, 1, 0, 0, 0, 1, 1); tick();
      id_set(1, 0, 1, 0, 1, 10, 1, 0); chk_stall("O_ldx0", 1'b0); tick();
      chk_out("O_ldx0", 2'b00, 2'b00, 1'b0);

      // Async reset while in LD_STALL
      id_set(1, 1, 1, 0, 0, 3, 1, 1); tick();
      id_set(1, 3, 1, 2, 1, 4, 1, 0); chk_stall("Q_lu", 1'b1); tick();
      chk_state("Q_lu", LD_STALL);
      #2 rst = 1'b1;
      #1;
      chk_out("rst_mid", 2'b00, 2'b00, 1'b1);
      chk("rst_mid_stall", 32'(stall_if_id), 32'd0);
      chk_state("rst_mid", RUN);
      chk_stats("rst_mid", 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // Memory wait in the middle of forwarding
      id_set(1, 1, 1, 2, 1, 5, 1, 0); tick();
      id_set(1, 5, 1, 5, 1, 6, 1, 0); tick();
      chk_out("S", 2'b01, 2'b01, 1'b0);
      mem_ready = 1'b0;
      id_set(1, 6, 1, 5, 1, 7, 1, 0);
      for (int i = 0; i < 3; i++) begin
         chk_stall($sformatf("T%0d_wait", i), 1'b1);
         tick();
         chk_out($sformatf("T%0d_wait", i), 2'b01, 2'b01, 1'b0);
         chk_state($sformatf("T%0d_wait", i), MEM_WAIT);
      end
      mem_ready = 1'b1;
      chk_stall("U_resume", 1'b0); tick();
      chk_out("U_resume", 2'b01, 2'b10, 1'b0);
      chk_state("U_resume", RUN);

      // Flush beats load-use
      id_set(1, 0, 0, 0, 0, 3, 1, 1); tick();
      flush = 1'b1;
      id_set(1, 3, 1, 2, 1, 4, 1, 0); chk_stall("W_flush", 1'b0); tick();
      chk_out("W_flush", 2'b00, 2'b00, 1'b1);
      chk_state("W_flush", RUN);
      chk_stats("W_flush", 0, 2);
      flush = 1'b0;

      // Flush during memory wait is held off until ready
      id_set(1, 0, 0, 0, 0, 3, 1, 1); tick();
      flush = 1'b1;
      mem_ready = 1'b0;
      id_set(1, 3, 1, 2, 1, 4, 1, 0); chk_stall("Y_fwait", 1'b1); tick();
      chk_out("Y_fwait", 2'b00, 2'b00, 1'b0);
      chk_state("Y_fwait", MEM_WAIT);
      mem_ready = 1'b1;
      chk_stall("Z_flush", 1'b0); tick();
      chk_out("Z_flush", 2'b00, 2'b00, 1'b1);
      chk_state("Z_flush", RUN);
      chk_stats("Z_flush", 0, 2);
      flush = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
